// File: rtl/operand_feeder_if.sv
// Operand feeder bus interface.
// Bundles the buffer-write port, the start request, the PE handshake and the
// status outputs of operand_feeder.
//   master : stimulus side (drives writes/start/pe_ready, observes operands/status)
//   slave  : operand_feeder side
interface operand_feeder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  wr_en;
    logic                  wr_sel;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  start;
    logic                  pe_ready;
    logic                  en_din;
    logic                  en_win;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] weights_in;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, pe_ready,
        input  en_din, en_win, data_in, weights_in, busy, done, err
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, pe_ready,
        output en_din, en_win, data_in, weights_in, busy, done, err
    );
endinterface

// File: rtl/operand_feeder.sv
// Operand feeder: holds a data buffer and a weight buffer of NUM_ELEM entries
// and, on start, streams them element by element to a PE, followed by one
// zero flush cycle, then waits a bounded time for the PE result pulse.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operand_feeder_if slave modport
//           in : wr_en, wr_sel, wr_addr, wr_data, start, pe_ready
//           out: en_din, en_win, data_in, weights_in, busy, done, err
// All outputs are registered.
module operand_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_ELEM   = 27
) (
    input logic              clk,
    input logic              rst_n,
    operand_feeder_if.slave  bus
);

    localparam logic [4:0] FlushIdx    = 5'(NUM_ELEM);
    localparam logic [4:0] LastDataIdx = 5'(NUM_ELEM - 1);
    localparam logic [1:0] WaitLast    = 2'd3;

    typedef enum logic [1:0] {StIdle, StStream, StWait} state_e;

    state_e                state_q, state_d;
    logic [4:0]            idx_q, idx_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] win_q, win_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    // Buffers are intentionally not reset.
    logic [DATA_WIDTH-1:0] data_mem   [NUM_ELEM];
    logic [DATA_WIDTH-1:0] weight_mem [NUM_ELEM];

    logic       wr_ok;
    logic [4:0] nxt_idx;

    // A start in the same cycle takes priority and drops the write.
    assign wr_ok   = bus.wr_en && (state_q == StIdle) && !bus.start
                     && (bus.wr_addr < FlushIdx);
    assign nxt_idx = idx_q + 5'd1;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            if (bus.wr_sel) begin
                weight_mem[bus.wr_addr] <= bus.wr_data;
            end else begin
                data_mem[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        en_d    = 1'b0;
        din_d   = '0;
        win_d   = '0;
        done_d  = 1'b0;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StStream;
                    idx_d   = 5'd0;
                    err_d   = 1'b0;
                    en_d    = 1'b1;
                    din_d   = data_mem[0];
                    win_d   = weight_mem[0];
                end
            end
            StStream: begin
                // idx_q is the stream cycle currently on the outputs; the
                // outputs computed here belong to cycle idx_q + 1.
                if (idx_q == FlushIdx) begin
                    state_d = StWait;
                    wcnt_d  = 2'd0;
                end else begin
                    en_d  = 1'b1;
                    idx_d = nxt_idx;
                    if (idx_q < LastDataIdx) begin
                        din_d = data_mem[nxt_idx];
                        win_d = weight_mem[nxt_idx];
                    end
                end
            end
            StWait: begin
                if (bus.pe_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (wcnt_q == WaitLast) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wcnt_q  <= '0;
            en_q    <= 1'b0;
            din_q   <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wcnt_q  <= wcnt_d;
            en_q    <= en_d;
            din_q   <= din_d;
            win_q   <= win_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.en_din     = en_q;
    assign bus.en_win     = en_q;
    assign bus.data_in    = din_q;
    assign bus.weights_in = win_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_operand_feeder.sv
module tb_operand_feeder;

    localparam int NE = 27;

    logic clk;
    logic rst_n;

    operand_feeder_if #(.DATA_WIDTH(8)) bus ();

    operand_feeder #(
        .DATA_WIDTH (8),
        .NUM_ELEM   (27)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Captured per-stream-cycle outputs: {en_din, en_win, busy}, data, weight
    logic [2:0] cap_ctl [28];
    logic [7:0] cap_d   [28];
    logic [7:0] cap_w   [28];
    logic       cap_err0;
    int         pe_acc;

    task automatic idle_inputs();
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_addr  = 5'd0;
        bus.wr_data  = 8'd0;
        bus.start    = 1'b0;
        bus.pe_ready = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic write_elem(input logic sel, input logic [4:0] addr, input logic [7:0] val);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr;
        bus.wr_data = val;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic load_default();
        for (int k = 0; k < NE; k++) begin
            write_elem(1'b0, 5'(k), 8'(k + 1));
            write_elem(1'b1, 5'(k), 8'd2);
        end
    endtask

    // Starts a window and captures the 28 stream cycles. If inj >= 0, during
    // stream cycle inj a start pulse and a write of 0xFF to data[0] are
    // driven. same_wr drives a write of 0xAA to data[0] with the start.
    // Called at posedge+1; returns at posedge+1 at the start of WAIT cycle 1.
    task automatic run_stream(input int inj, input logic same_wr);
        bus.start = 1'b1;
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_addr = 5'd0;
            bus.wr_data = 8'hAA;
        end
        @(posedge clk); #1;
        idle_inputs();
        pe_acc = 0;
        for (int k = 0; k < 28; k++) begin
            if (k == inj) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'b0;
                bus.wr_addr = 5'd0;
                bus.wr_data = 8'hFF;
            end
            @(negedge clk);
            cap_ctl[k] = {bus.en_din, bus.en_win, bus.busy};
            cap_d[k]   = bus.data_in;
            cap_w[k]   = bus.weights_in;
            if (k == 0) cap_err0 = bus.err;
            if (bus.en_din && bus.en_win) pe_acc += int'(bus.data_in) * int'(bus.weights_in);
            @(posedge clk); #1;
            idle_inputs();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        total++;
        if ({bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done, bus.err}
            !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b%b d=%h w=%h busy=%b done=%b err=%b want all 0",
                     bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done,
                     bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stream_done();
        int nbad;
        load_default();
        // pe_ready outside WAIT must be ignored
        bus.pe_ready = 1'b1;
        @(posedge clk); #1;
        bus.pe_ready = 1'b0;
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_pe_ready: got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
        @(posedge clk); #1;
        run_stream(-1, 1'b0);
        nbad = 0;
        for (int k = 0; k < 28; k++) begin
            total++;
            if (cap_ctl[k] !== 3'b111 || cap_d[k] !== ((k < NE) ? 8'(k + 1) : 8'd0)
                || cap_w[k] !== ((k < NE) ? 8'd2 : 8'd0)) begin
                bad++;
                $display("FAIL stream_cycle%0d: got ctl=%b d=%0d w=%0d want ctl=111 d=%0d w=%0d",
                         k, cap_ctl[k], cap_d[k], cap_w[k], (k < NE) ? k + 1 : 0,
                         (k < NE) ? 2 : 0);
            end
        end
        total++;
        if (pe_acc !== 756) begin
            bad++;
            $display("FAIL pe_sum: got %0d want 756", pe_acc);
        end
        // WAIT cycle 1: outputs quiet, busy still high; PE answers now
        bus.pe_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done}
            !== {18'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wait_state: got en=%b%b d=%h w=%h busy=%b done=%b want 00 0 0 1 0",
                     bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done);
        end
        @(posedge clk); #1;
        bus.pe_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy, bus.err} !== 3'b100) begin
            bad++;
            $display("FAIL done_pulse: got done=%b busy=%b err=%b want 1 0 0",
                     bus.done, bus.busy, bus.err);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: got done=%b want 0", bus.done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        run_stream(-1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if ({bus.busy, bus.err, bus.done} !== 3'b100) begin
                bad++;
                $display("FAIL wait_cycle%0d: got busy=%b err=%b done=%b want 1 0 0",
                         i, bus.busy, bus.err, bus.done);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({bus.busy, bus.err, bus.done} !== 3'b010) begin
                bad++;
                $display("FAIL timeout_err%0d: got busy=%b err=%b done=%b want 0 1 0",
                         i, bus.busy, bus.err, bus.done);
            end
            @(posedge clk); #1;
        end
        run_stream(-1, 1'b0);
        total++;
        if (cap_err0 !== 1'b0) begin
            bad++;
            $display("FAIL err_clear: got err=%b want 0", cap_err0);
        end
        bus.pe_ready = 1'b1;
        @(posedge clk); #1;
        bus.pe_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_mid_stream();
        run_stream(5, 1'b0);
        for (int k = 0; k < 28; k++) begin
            total++;
            if (cap_ctl[k] !== 3'b111 || cap_d[k] !== ((k < NE) ? 8'(k + 1) : 8'd0)) begin
                bad++;
                $display("FAIL inject_cycle%0d: got ctl=%b d=%0d want ctl=111 d=%0d",
                         k, cap_ctl[k], cap_d[k], (k < NE) ? k + 1 : 0);
            end
        end
        // No pe_ready: if the mid-stream start had been taken the FSM would
        // still be streaming here rather than timing out.
        repeat (4) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if ({bus.busy, bus.err} !== 2'b01) begin
            bad++;
            $display("FAIL inject_timeout: got busy=%b err=%b want 0 1", bus.busy, bus.err);
        end
        @(posedge clk); #1;
        write_elem(1'b0, 5'd27, 8'h55);
        write_elem(1'b1, 5'd27, 8'h55);
    endtask

    task automatic test_start_with_write();
        run_stream(-1, 1'b1);
        total++;
        if (cap_d[0] !== 8'd1 || cap_d[26] !== 8'd27 || cap_w[26] !== 8'd2) begin
            bad++;
            $display("FAIL start_write: got d0=%0d d26=%0d w26=%0d want 1 27 2",
                     cap_d[0], cap_d[26], cap_w[26]);
        end
        bus.pe_ready = 1'b1;
        @(posedge clk); #1;
        bus.pe_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream();
        int nb;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (bus.data_in !== 8'd11 || bus.en_din !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_cycle10: got d=%0d en=%b want 11 1", bus.data_in, bus.en_din);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done, bus.err}
            !== 21'd0) begin
            bad++;
            $display("FAIL async_reset: got en=%b%b d=%h w=%h busy=%b done=%b err=%b want all 0",
                     bus.en_din, bus.en_win, bus.data_in, bus.weights_in, bus.busy, bus.done,
                     bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_default();
        run_stream(-1, 1'b0);
        nb = 0;
        for (int k = 0; k < 28; k++) begin
            if (cap_ctl[k] !== 3'b111 || cap_d[k] !== ((k < NE) ? 8'(k + 1) : 8'd0)
                || cap_w[k] !== ((k < NE) ? 8'd2 : 8'd0)) nb++;
        end
        total++;
        if (nb != 0 || pe_acc !== 756) begin
            bad++;
            $display("FAIL restream_after_reset: got %0d bad cycles sum=%0d want 0 bad sum=756",
                     nb, pe_acc);
        end
        bus.pe_ready = 1'b1;
        @(posedge clk); #1;
        bus.pe_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL restream_done: got done=%b busy=%b want 1 0", bus.done, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_stream_done();
        test_timeout();
        test_ignore_mid_stream();
        test_start_with_write();
        test_reset_mid_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter NUM_ELEM, default 27, products per 3x3x3 window (fixed; not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  buffer write strobe.
REQ-006 wr_sel  input  1  write target: 0 = data buffer, 1 = weight buffer.
REQ-007 wr_addr  input  5  buffer element index.
REQ-008 wr_data  input  DATA_WIDTH  element value.
REQ-009 start  input  1  request to stream one window.
REQ-010 pe_ready  input  1  result-valid pulse from the downstream PE.
REQ-011 en_din  output  1  data-operand enable to the PE.
REQ-012 en_win  output  1  weight-operand enable to the PE.
REQ-013 data_in  output  DATA_WIDTH  data operand to the PE.
REQ-014 weights_in  output  DATA_WIDTH  weight operand to the PE.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse, window result received.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 SHALL hold two NUM_ELEM-entry buffers (data, weight), DATA_WIDTH wide, not reset.
REQ-019 Write SHALL occur at the edge where wr_en=1, state=IDLE, start=0 and wr_addr<NUM_ELEM; otherwise write dropped, no other effect.
REQ-020 FSM states: IDLE, STREAM, WAIT; all outputs registered.
REQ-021 IDLE->STREAM on start=1; err cleared and index reset to 0 at that edge.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 STREAM SHALL last exactly NUM_ELEM+1 = 28 consecutive cycles, en_din=en_win=1 in every one, never interrupted.
REQ-024 Stream cycle k (k=0..26) SHALL drive data_in=data[k], weights_in=weight[k]; cycle 27 SHALL drive both 0 (PE flush/capture cycle).
REQ-025 First stream cycle SHALL be the cycle after the start edge.
REQ-026 After stream cycle 27, STREAM->WAIT; en_din=en_win=0, data_in=weights_in=0 outside STREAM.
REQ-027 In WAIT, pe_ready=1 SHALL cause done=1 for the next cycle and WAIT->IDLE.
REQ-028 WAIT SHALL time out after 4 cycles without pe_ready: err<=1, ->IDLE, no done.
REQ-029 pe_ready while not in WAIT SHALL be ignored.
REQ-030 err SHALL stay 1 until the next accepted start or reset.
REQ-031 busy SHALL be 1 from the cycle after the start edge through the last WAIT cycle.
REQ-032 Buffer contents SHALL persist across windows; restart without rewrite reuses them.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, index 0, en_din=0, en_win=0, data_in=0, weights_in=0, busy=0, done=0, err=0, including mid-STREAM or mid-WAIT.
REQ-034 Buffer contents after reset SHALL be undefined; bench SHALL write before streaming.

Verification
REQ-035 Write data[k]=k+1, weight[k]=2 for k=0..26, start -> 28 cycles en_din=en_win=1, data_in 1..27 then 0, weights_in 2 (x27) then 0; PE model gives 756.
REQ-036 pe_ready 1 cycle after last stream cycle -> done=1 for exactly one cycle, busy falls same cycle, err=0.
REQ-037 No pe_ready in WAIT -> err=1 after 4 WAIT cycles, done stays 0; next start clears err.
REQ-038 start pulsed and wr_en to addr 0 (value 0xFF) mid-STREAM -> both ignored, stream unchanged; wr_addr=27 in IDLE -> no buffer change.
REQ-039 start and wr_en to addr 0 same cycle in IDLE -> stream starts, write dropped, data_in cycle 0 = old value.
REQ-040 rst_n=0 at stream cycle 10 -> all outputs 0 asynchronously; after release, start with same buffers (rewritten) -> full 28-cycle stream.
